result_deskew: RTL and testbench

RESULT_DESKEW -- requirements
Module: result_deskew

---
 rtl/result_deskew.sv | 188 ++++++++++++++++++
 tb/tb_result_deskew.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/result_deskew.sv
// result_deskew: realigns the skewed column outputs of a DIM x DIM systolic
// array into whole rows, stores one DIM x DIM result matrix and serves it a
// row at a time.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   start, clr        arm a capture (IDLE only) / abandon and return to IDLE
//   cin, cin_valid    skewed column data and per-column qualifiers
//   rd_req, rd_row    row read request and row index (FULL only)
//   rd_data, rd_valid row read back, valid one cycle after rd_req
//   busy, done        state flags: CAPTURE / FULL
//   ovf               (only with RESULT_DESKEW_OVF_EN) sticky overflow flag
//
// Optional feature: define RESULT_DESKEW_OVF_EN to add the ovf output.
module result_deskew #(
  parameter int BITS_C = 16,
  parameter int DIM    = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     clr,
  input  logic signed [BITS_C-1:0] cin [DIM],
  input  logic [DIM-1:0]           cin_valid,
  input  logic                     rd_req,
  input  logic [$clog2(DIM)-1:0]   rd_row,
  output logic signed [BITS_C-1:0] rd_data [DIM],
  output logic                     rd_valid,
  output logic                     busy,
  output logic                     done
`ifdef RESULT_DESKEW_OVF_EN
  ,
  output logic                     ovf
`endif
);

  localparam int RW = $clog2(DIM);
  // row_cnt carries one extra bit so it can hold DIM once the matrix is full
  localparam logic [RW:0] DIM_W  = (RW+1)'(DIM);
  localparam logic [RW:0] LAST_W = (RW+1)'(DIM - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    FULL    = 2'd2
  } state_t;

  state_t                    state_r;
  state_t                    state_nxt_s;
  logic [RW:0]               row_cnt_r;
  logic                      start_acc_s;
  logic                      dsk_clr_s;
  logic                      wr_en_s;
  logic                      rd_acc_s;
  logic [RW-1:0]             rd_idx_s;
  logic signed [BITS_C-1:0]  al_data_s [DIM];
  logic [DIM-1:0]            al_vld_s;
  logic signed [BITS_C-1:0]  row_buf_r [DIM][DIM];

  assign start_acc_s = (state_r == IDLE) && start && !clr;
  assign dsk_clr_s   = start_acc_s || clr;
  // column 0 is the most delayed column, so its valid marks a complete row
  assign wr_en_s     = (state_r == CAPTURE) && al_vld_s[0] && !clr;
  assign rd_acc_s    = (state_r == FULL) && rd_req;

  // Out-of-range row indices fall back to row 0
  always_comb begin
    rd_idx_s = '0;
    if ({1'b0, rd_row} < DIM_W) begin
      rd_idx_s = rd_row;
    end else begin
      rd_idx_s = '0;
    end
  end

  // Deskew: column j is delayed by DIM-1-j stages, data and valid together
  for (genvar j = 0; j < DIM; j++) begin : g_col
    localparam int DEPTH = DIM - 1 - j;
    if (DEPTH == 0) begin : g_pass
      assign al_data_s[j] = cin[j];
      assign al_vld_s[j]  = cin_valid[j];
    end else begin : g_dly
      logic signed [BITS_C-1:0] data_r [DEPTH];
      logic [DEPTH-1:0]         vld_r;

      // Per-column delay line, cleared whenever a capture is armed or abandoned
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int k = 0; k < DEPTH; k++) data_r[k] <= '0;
          vld_r <= '0;
        end else if (dsk_clr_s) begin
          for (int k = 0; k < DEPTH; k++) data_r[k] <= '0;
          vld_r <= '0;
        end else begin
          data_r[0] <= cin[j];
          vld_r[0]  <= cin_valid[j];
          for (int k = 1; k < DEPTH; k++) begin
            data_r[k] <= data_r[k-1];
            vld_r[k]  <= vld_r[k-1];
          end
        end
      end

      assign al_data_s[j] = data_r[DEPTH-1];
      assign al_vld_s[j]  = vld_r[DEPTH-1];
    end
  end

  // Next-state logic; clr overrides everything, start only counts in IDLE
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) state_nxt_s = CAPTURE;
        else       state_nxt_s = IDLE;
      end
      CAPTURE: begin
        if (wr_en_s && (row_cnt_r == LAST_W)) state_nxt_s = FULL;
        else                                  state_nxt_s = CAPTURE;
      end
      FULL:    state_nxt_s = FULL;
      default: state_nxt_s = IDLE;
    endcase
    if (clr) begin
      state_nxt_s = IDLE;
    end else begin
      state_nxt_s = state_nxt_s;
    end
  end

  // State register, row counter and registered status flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      row_cnt_r <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      busy    <= (state_nxt_s == CAPTURE);
      done    <= (state_nxt_s == FULL);
      if (dsk_clr_s) begin
        row_cnt_r <= '0;
      end else if (wr_en_s) begin
        row_cnt_r <= row_cnt_r + {{RW{1'b0}}, 1'b1};
      end
    end
  end

  // Row buffer: no reset, contents are only meaningful after a full capture
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      for (int j = 0; j < DIM; j++) row_buf_r[row_cnt_r[RW-1:0]][j] <= al_data_s[j];
    end
  end

  // Read port: one-cycle latency, rd_data holds between accepted reads
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid <= 1'b0;
      for (int j = 0; j < DIM; j++) rd_data[j] <= '0;
    end else begin
      rd_valid <= rd_acc_s;
      if (rd_acc_s) begin
        for (int j = 0; j < DIM; j++) rd_data[j] <= row_buf_r[rd_idx_s][j];
      end
    end
  end

`ifdef RESULT_DESKEW_OVF_EN
  // Sticky overflow: traffic after the matrix is complete
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf <= 1'b0;
    end else if (start || clr) begin
      ovf <= 1'b0;
    end else if (((state_r == FULL) && (|cin_valid)) ||
                 ((|al_vld_s) && (row_cnt_r == DIM_W))) begin
      ovf <= 1'b1;
    end
  end
`else
  // Only column 0's aligned valid drives the write; the rest stay unread
  logic vld_unused_s;
  assign vld_unused_s = ^al_vld_s;
`endif

endmodule

// File: tb/tb_result_deskew.sv
// Self-checking bench for result_deskew (DIM=8, BITS_C=16): table-driven row
// reads plus hand-written capture, clr, start/clr and reset sequences.
module tb_result_deskew;

  logic               clk;
  logic               rst_n;
  logic               start;
  logic               clr;
  logic signed [15:0] cin [8];
  logic [7:0]         cin_valid;
  logic               rd_req;
  logic [2:0]         rd_row;
  logic signed [15:0] rd_data [8];
  logic               rd_valid;
  logic               busy;
  logic               done;
`ifdef RESULT_DESKEW_OVF_EN
  logic               ovf;
`endif

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic       req;
    logic [2:0] row;
    logic       exp_valid;
    int         exp0;      // expected element 0 of rd_data; element j = exp0+j
  } rd_vec_t;

  rd_vec_t tbl [10];

  result_deskew #(.BITS_C(16), .DIM(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .clr       (clr),
    .cin       (cin),
    .cin_valid (cin_valid),
    .rd_req    (rd_req),
    .rd_row    (rd_row),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .busy      (busy),
    .done      (done)
`ifdef RESULT_DESKEW_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // mode 0: element j = exp0+j, mode 1: all 0xFFFF, mode 2: all zero
  task automatic chk_row(input string name, input int mode, input int exp0);
    logic [15:0] e;
    logic [15:0] got_b = 16'h0;
    logic [15:0] exp_b = 16'h0;
    int          col_b = 0;
    bit          ok = 1'b1;
    for (int j = 0; j < 8; j++) begin
      if (mode == 0)      e = 16'(exp0 + j);
      else if (mode == 1) e = 16'hFFFF;
      else                e = 16'h0000;
      if (ok && (rd_data[j] !== e)) begin
        ok = 1'b0; col_b = j; got_b = rd_data[j]; exp_b = e;
      end
    end
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s: col %0d got %0h expected %0h", name, col_b, got_b, exp_b);
    end
  endtask

  task automatic idle_inputs();
    for (int j = 0; j < 8; j++) cin[j] = 16'sd0;
    cin_valid = 8'h00;
  endtask

  // Present skewed element (r, c-r...) for cycle c of a capture
  task automatic drive_cycle(input int c, input bit ones);
    for (int j = 0; j < 8; j++) begin
      int r;
      r = c - j;
      if (r >= 0 && r < 8) begin
        cin[j]       = ones ? 16'hFFFF : 16'(16 * r + j);
        cin_valid[j] = 1'b1;
      end else begin
        cin[j]       = 16'sd0;
        cin_valid[j] = 1'b0;
      end
    end
  endtask

  // start, then ncyc skewed cycles; done must rise exactly after cycle 14
  task automatic capture(input bit ones, input int ncyc);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("busy_after_start", busy, 32'd1);
    for (int c = 0; c < ncyc; c++) begin
      drive_cycle(c, ones);
      tick();
      chk("done_timing", done, (c == 14) ? 32'd1 : 32'd0);
      chk("busy_timing", busy, (c == 14) ? 32'd0 : 32'd1);
    end
    idle_inputs();
  endtask

  initial begin
    // rows 3 then 0..7 back to back, then an idle cycle that must hold row 7
    tbl[0] = '{1'b1, 3'd3, 1'b1, 48};
    for (int i = 0; i < 8; i++) tbl[i+1] = '{1'b1, 3'(i), 1'b1, 16 * i};
    tbl[9] = '{1'b0, 3'd0, 1'b0, 112};

    rst_n = 1'b0; start = 1'b0; clr = 1'b0; rd_req = 1'b0; rd_row = 3'd0;
    idle_inputs();
    #12;
    chk("reset_busy", busy, 32'd0);
    chk("reset_done", done, 32'd0);
    chk("reset_rd_valid", rd_valid, 32'd0);
    chk_row("reset_rd_data", 2, 0);
    rst_n = 1'b1;
    tick();

    // read in IDLE is ignored
    rd_req = 1'b1; rd_row = 3'd3;
    tick();
    rd_req = 1'b0;
    chk("idle_read_valid", rd_valid, 32'd0);

    // start and clr together: stay in IDLE
    start = 1'b1; clr = 1'b1;
    tick();
    start = 1'b0; clr = 1'b0;
    chk("start_clr_busy", busy, 32'd0);
    chk("start_clr_done", done, 32'd0);
    tick();
    chk("start_clr_busy2", busy, 32'd0);

    // full capture of 16*r+j
    capture(1'b0, 15);
`ifdef RESULT_DESKEW_OVF_EN
    chk("ovf_clear_full", ovf, 32'd0);
`endif

    // start in FULL is ignored
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("start_in_full_done", done, 32'd1);
    chk("start_in_full_busy", busy, 32'd0);

    // table-driven back-to-back reads
    for (int i = 0; i < 10; i++) begin
      rd_req = tbl[i].req;
      rd_row = tbl[i].row;
      tick();
      chk("rd_valid_tbl", rd_valid, {31'd0, tbl[i].exp_valid});
      chk_row("rd_data_tbl", 0, tbl[i].exp0);
    end
    rd_req = 1'b0;

    // stray valids in FULL must not touch the buffer
    for (int j = 0; j < 8; j++) cin[j] = 16'sh1234;
    cin_valid = 8'hFF;
    tick();
    idle_inputs();
`ifdef RESULT_DESKEW_OVF_EN
    chk("ovf_set", ovf, 32'd1);
`endif
    for (int k = 0; k < 8; k++) tick();
    chk("full_stray_done", done, 32'd1);
    rd_req = 1'b1; rd_row = 3'd0;
    tick();
    rd_row = 3'd5;
    chk_row("stray_row0", 0, 0);
    tick();
    rd_req = 1'b0;
    chk_row("stray_row5", 0, 80);

    // read accepted on the clr edge still completes
    rd_req = 1'b1; rd_row = 3'd2; clr = 1'b1;
    tick();
    rd_req = 1'b0; clr = 1'b0;
    chk("clr_read_valid", rd_valid, 32'd1);
    chk_row("clr_read_data", 0, 32);
    chk("clr_done", done, 32'd0);
    chk("clr_busy", busy, 32'd0);
`ifdef RESULT_DESKEW_OVF_EN
    chk("ovf_cleared", ovf, 32'd0);
`endif

    // read after clr (IDLE) ignored, data held
    rd_req = 1'b1; rd_row = 3'd6;
    tick();
    rd_req = 1'b0;
    chk("post_clr_read_valid", rd_valid, 32'd0);
    chk_row("post_clr_read_hold", 0, 32);

    // reset mid-capture after rows 0..3 written
    capture(1'b0, 11);
    chk("partial_busy", busy, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_busy", busy, 32'd0);
    chk("async_rst_done", done, 32'd0);
    chk("async_rst_valid", rd_valid, 32'd0);
    chk_row("async_rst_data", 2, 0);
    #2;
    rst_n = 1'b1;
    tick();
    chk("post_rst_busy", busy, 32'd0);

    // recapture all -1 and read every row
    capture(1'b1, 15);
    for (int r = 0; r < 8; r++) begin
      rd_req = 1'b1; rd_row = 3'(r);
      tick();
      chk("ones_rd_valid", rd_valid, 32'd1);
      chk_row("ones_rd_data", 1, 0);
    end
    rd_req = 1'b0;
    tick();
    chk("ones_rd_valid_end", rd_valid, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
